// File: rtl/wb_trace_buffer.sv
// Writeback trace FIFO: captures wb bus events, reads them back 16 bits at a time.
// Optional WB_TRACE_TIMESTAMP_EN stamps each entry with a 13-bit cycle counter.
module wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AL_W  = 6,
    parameter int RD_W  = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                freeze,
    input  logic                clear,
    input  logic [3:0]          wb_valid,
    input  logic [3:0]          wb_uses_rd,
    input  logic [4*AL_W-1:0]   wb_al_idx,
    input  logic [4*RD_W-1:0]   wb_rd,
    input  logic [127:0]        wb_data,
    input  logic [3:0]          switches,
    input  logic                pop,
    output logic [15:0]         r1,
    output logic                empty,
    output logic                overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_q, drop_d;
    logic          pop_q;
    logic [63:0]   mem_q [DEPTH];

    logic [12:0]   ts;
    logic          cap_en;
    logic          pop_fire;
    logic [CW-1:0] free;
    logic [2:0]    npush;
    logic [2:0]    ndrop;
    logic [8:0]    drop_sum;
    logic [3:0]    wen;
    logic [PW-1:0] widx [4];
    logic [63:0]   went [4];
    logic [63:0]   head;
    logic          unused_sw;

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [12:0] ts_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 13'd1;
        end
    end

    assign ts = ts_q;
`else
    assign ts = 13'd0;
`endif

    assign cap_en   = ~freeze & ~clear;
    assign pop_fire = pop & ~pop_q & (count_q != '0);
    assign free     = CW'(DEPTH) - count_q;

    // Ports are granted free slots in ascending order; the rest are drops.
    always_comb begin
        npush = 3'd0;
        ndrop = 3'd0;
        wen   = 4'b0;
        for (int i = 0; i < 4; i++) begin
            widx[i] = '0;
            went[i] = {ts, wb_uses_rd[i], 2'(i),
                       8'(wb_rd[i*RD_W +: RD_W]),
                       8'(wb_al_idx[i*AL_W +: AL_W]),
                       wb_data[i*32 +: 32]};
        end
        for (int i = 0; i < 4; i++) begin
            if (cap_en && wb_valid[i]) begin
                if (CW'(npush) < free) begin
                    wen[i]  = 1'b1;
                    widx[i] = wptr_q + PW'(npush);
                    npush   = npush + 3'd1;
                end else begin
                    ndrop = ndrop + 3'd1;
                end
            end
        end
    end

    assign drop_sum = {1'b0, drop_q} + 9'(ndrop);

    always_comb begin
        count_d    = count_q + CW'(npush) - CW'(pop_fire);
        wptr_d     = wptr_q + PW'(npush);
        rptr_d     = rptr_q + PW'(pop_fire);
        overflow_d = overflow_q | (ndrop != 3'd0);
        drop_d     = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        if (clear) begin
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            overflow_d = 1'b0;
            drop_d     = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= 8'd0;
            pop_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            pop_q      <= pop;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                mem_q[widx[i]] <= went[i];
            end
        end
    end

    assign head      = mem_q[rptr_q];
    assign empty     = (count_q == '0);
    assign overflow  = overflow_q;
    assign unused_sw = switches[3];

    always_comb begin
        if (switches[2]) begin
            r1 = {overflow_q, empty, 6'(count_q), drop_q};
        end else if (empty) begin
            r1 = 16'h0000;
        end else begin
            r1 = head[{switches[1:0], 4'b0000} +: 16];
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: expected entries are queued at
// capture and compared slice by slice as they reach the FIFO head.
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AL_W  = 6;
    localparam int RD_W  = 6;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                freeze = 1'b0;
    logic                clear = 1'b0;
    logic [3:0]          wb_valid = '0;
    logic [3:0]          wb_uses_rd = '0;
    logic [4*AL_W-1:0]   wb_al_idx = '0;
    logic [4*RD_W-1:0]   wb_rd = '0;
    logic [127:0]        wb_data = '0;
    logic [3:0]          switches = '0;
    logic                pop = 1'b0;
    logic [15:0]         r1;
    logic                empty;
    logic                overflow;

    int          checks = 0;
    int          errors = 0;
    int          tb_cyc = 0;
    logic [63:0] sb [$];
    logic        m_ovf = 1'b0;
    logic [7:0]  m_drop = 8'd0;
    logic        m_popq = 1'b0;

    wb_trace_buffer #(
        .DEPTH(DEPTH),
        .AL_W (AL_W),
        .RD_W (RD_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .freeze    (freeze),
        .clear     (clear),
        .wb_valid  (wb_valid),
        .wb_uses_rd(wb_uses_rd),
        .wb_al_idx (wb_al_idx),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .switches  (switches),
        .pop       (pop),
        .r1        (r1),
        .empty     (empty),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] exp_ts();
`ifdef WB_TRACE_TIMESTAMP_EN
        return 13'(tb_cyc);
`else
        return 13'd0;
`endif
    endfunction

    task automatic rand_fields();
        wb_data    = {$urandom, $urandom, $urandom, $urandom};
        wb_rd      = 24'($urandom);
        wb_al_idx  = 24'($urandom);
        wb_uses_rd = 4'($urandom);
    endtask

    // One clock with the given valid mask and pop level; model updated first.
    task automatic drive(logic [3:0] v, logic p);
        int  free;
        int  taken;
        bit  fire;
        free  = DEPTH - sb.size();
        taken = 0;
        fire  = p && !m_popq && (sb.size() > 0);
        m_popq = p;
        if (clear) begin
            sb.delete();
            m_ovf  = 1'b0;
            m_drop = 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (v[i] && !freeze) begin
                    if (taken < free) begin
                        sb.push_back({exp_ts(), wb_uses_rd[i], 2'(i),
                                      8'(wb_rd[i*RD_W +: RD_W]),
                                      8'(wb_al_idx[i*AL_W +: AL_W]),
                                      wb_data[i*32 +: 32]});
                        taken++;
                    end else begin
                        m_ovf  = 1'b1;
                        m_drop = (m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1;
                    end
                end
            end
            if (fire) void'(sb.pop_front());
        end
        wb_valid = v;
        pop      = p;
        tick();
        wb_valid = '0;
    endtask

    task automatic check_head(string tag);
        logic [63:0] got;
        for (int s = 0; s < 4; s++) begin
            switches = 4'(s);
            #1;
            got[s*16 +: 16] = r1;
        end
        switches = 4'd0;
        if (sb.size() > 0) check(tag, got, sb[0]);
        else               check(tag, got, 64'd0);
    endtask

    task automatic check_status(string tag);
        switches = 4'b0100;
        #1;
        check(tag, {48'd0, r1},
              {48'd0, m_ovf, sb.size() == 0, 6'(sb.size()), m_drop});
        switches = 4'd0;
        #1;
    endtask

    initial begin
        switches = 4'b0100;
        #3 reset = 1'b0;
        #1;
        check("rst_empty", {63'd0, empty}, 64'd1);
        check("rst_ovf", {63'd0, overflow}, 64'd0);
        check("rst_status", {48'd0, r1}, 64'h4000);
        switches = 4'd0;
        #1;
        check("rst_r1", {48'd0, r1}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 20 && tb_cyc < 5; k++) tick();
        check("ts_sync", 64'(tb_cyc), 64'd5);
        wb_data[64 +: 32]       = 32'hDEADBEEF;
        wb_rd[2*RD_W +: RD_W]   = 6'd5;
        wb_al_idx[2*AL_W +: AL_W] = 6'd3;
        wb_uses_rd              = 4'b0100;
        drive(4'b0100, 1'b0);
        check("cap_empty", {63'd0, empty}, 64'd0);
        switches = 4'd0; #1;
        check("slice0", {48'd0, r1}, 64'hBEEF);
        switches = 4'd1; #1;
        check("slice1", {48'd0, r1}, 64'hDEAD);
        switches = 4'd2; #1;
        check("slice2", {48'd0, r1}, 64'h0503);
        switches = 4'd3; #1;
        check("slice3_lo", {61'd0, r1[2:0]}, 64'b110);
`ifdef WB_TRACE_TIMESTAMP_EN
        check("slice3_ts", {51'd0, r1[15:3]}, 64'd5);
`else
        check("slice3_ts", {51'd0, r1[15:3]}, 64'd0);
`endif
        check_head("head_single");
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b0);
        check("pop_single_empty", {63'd0, empty}, 64'd1);

        rand_fields();
        drive(4'b1111, 1'b0);
        switches = 4'b0100; #1;
        check("four_count", {58'd0, r1[13:8]}, 64'd4);
        check_status("four_status");
        for (int k = 0; k < 4; k++) begin
            switches = 4'd3; #1;
            check("four_port", {62'd0, r1[1:0]}, 64'(k));
            check_head("four_head");
            drive(4'b0000, 1'b1);
            drive(4'b0000, 1'b0);
        end
        check("four_empty", {63'd0, empty}, 64'd1);

        for (int k = 0; k < 14; k++) begin
            rand_fields();
            drive(4'b0001, 1'b0);
        end
        rand_fields();
        drive(4'b1111, 1'b0);
        switches = 4'b0100; #1;
        check("ovf_drop", {56'd0, r1[7:0]}, 64'd2);
        check("ovf_count", {58'd0, r1[13:8]}, 64'd16);
        check("ovf_flag", {63'd0, overflow}, 64'd1);
        check_status("ovf_status");

        for (int k = 0; k < 10; k++) drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b0);
        switches = 4'b0100; #1;
        check("hold_count", {58'd0, r1[13:8]}, 64'd15);
        check_status("hold_status");

        for (int k = 0; k < 40 && sb.size() > 0; k++) begin
            check_head("drain_head");
            drive(4'b0000, 1'b1);
            drive(4'b0000, 1'b0);
        end
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b0);
        check("empty_pop", {63'd0, empty}, 64'd1);
        check_status("empty_pop_status");

        freeze = 1'b1;
        rand_fields();
        drive(4'b1111, 1'b0);
        freeze = 1'b0;
        check_status("freeze_status");

        rand_fields();
        drive(4'b0011, 1'b0);
        drive(4'b0011, 1'b0);
        clear = 1'b1;
        drive(4'b1111, 1'b1);
        clear = 1'b0;
        drive(4'b0000, 1'b0);
        switches = 4'b0100; #1;
        check("clear_status", {48'd0, r1}, 64'h4000);
        check_status("clear_model");

        for (int k = 0; k < 60; k++) begin
            rand_fields();
            drive(4'($urandom), 1'($urandom_range(0, 1)));
            check_head("rand_head");
            check_status("rand_status");
        end

        for (int k = 0; k < 80; k++) begin
            rand_fields();
            drive(4'b1111, 1'b0);
        end
        switches = 4'b0100; #1;
        check("sat_drop", {56'd0, r1[7:0]}, 64'd255);
        check_status("sat_status");
        check_head("sat_head");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
